alu_exec_unit: RTL and testbench

- Parametrised successor to the CPU's combinational ALU-control decoder.
- Decodes `alu_ct_op` and `funct` into an operation and executes it on WIDTH-bit operands.
- Single-cycle ops return a registered result one cycle after acceptance. Unsigned multiply and divide run iteratively and write HI/LO.
- Sits in the EX stage between the main decoder and writeback, with valid/ready handshakes on both sides.

---
 rtl/alu_exec_unit.sv | 205 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes alu_ct_op/funct, runs single-cycle ops directly and
// unsigned MULTU/DIVU iteratively (one bit per cycle) into HI/LO.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_ct_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             illegal,
    output logic             div_zero
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO, OP_ILL
    } op_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               illegal_q, illegal_d, div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    op_t                op;
    logic               accept;
    logic               last_iter;
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        op = OP_ILL;
        case (alu_ct_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100001: op = OP_ADD;
                    6'b100011: op = OP_SUB;
                    6'b100100: op = OP_AND;
                    6'b100101: op = OP_OR;
                    6'b100110: op = OP_XOR;
                    6'b100111: op = OP_NOR;
                    6'b101010: op = OP_SLT;
                    6'b101011: op = OP_SLTU;
                    6'b011001: op = OP_MULTU;
                    6'b011011: op = OP_DIVU;
                    6'b010000: op = OP_MFHI;
                    6'b010010: op = OP_MFLO;
                    default:   op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
    end

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_iter = (cnt_inc == CNT_W'(WIDTH));

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, opnd_q};
    assign div_ge    = !div_diff[WIDTH];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            illegal_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            illegal_q   <= illegal_d;
            div_zero_q  <= div_zero_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && op == OP_MULTU)
                    state_d = MUL;
                else if (accept && op == OP_DIVU && src_b != '0)
                    state_d = DIV;
            end
            MUL, DIV: if (last_iter) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        illegal_d   = illegal_q;
        div_zero_d  = div_zero_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULTU: begin
                            opnd_d = src_a;
                            acc_d  = {{WIDTH{1'b0}}, src_b};
                            cnt_d  = '0;
                        end
                        OP_DIVU: begin
                            if (src_b == '0) begin
                                out_valid_d = 1'b1;
                                result_d    = '1;
                                lo_d        = '1;
                                hi_d        = src_a;
                                illegal_d   = 1'b0;
                                div_zero_d  = 1'b1;
                            end else begin
                                opnd_d = src_b;
                                acc_d  = {{WIDTH{1'b0}}, src_a};
                                cnt_d  = '0;
                            end
                        end
                        default: begin
                            out_valid_d = 1'b1;
                            illegal_d   = (op == OP_ILL);
                            div_zero_d  = 1'b0;
                            case (op)
                                OP_ADD:  result_d = src_a + src_b;
                                OP_SUB:  result_d = src_a - src_b;
                                OP_AND:  result_d = src_a & src_b;
                                OP_OR:   result_d = src_a | src_b;
                                OP_XOR:  result_d = src_a ^ src_b;
                                OP_NOR:  result_d = ~(src_a | src_b);
                                OP_SLT:  result_d = WIDTH'($signed(src_a) < $signed(src_b));
                                OP_SLTU: result_d = WIDTH'(src_a < src_b);
                                OP_MFHI: result_d = hi_q;
                                OP_MFLO: result_d = lo_q;
                                default: result_d = '0;
                            endcase
                        end
                    endcase
                end
            end
            MUL, DIV: begin
                acc_d = (state_q == MUL) ? mul_next : div_next;
                cnt_d = cnt_inc;
                if (last_iter) begin
                    hi_d = acc_d[2*WIDTH-1:WIDTH];
                    lo_d = acc_d[WIDTH-1:0];
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                result_d    = lo_q;
                illegal_d   = 1'b0;
                div_zero_d  = 1'b0;
            end
            default: ;
        endcase
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign illegal   = illegal_q;
    assign div_zero  = div_zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: a vector table of single-cycle ops plus
// hand-written multiply/divide, back-pressure and mid-operation reset sequences.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   alu_ct_op;
    logic [5:0]   funct;
    logic [W-1:0] src_a, src_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result, hi, lo;
    logic         illegal, div_zero;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string        name;
        logic [1:0]   ct;
        logic [5:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ill;
    } vec_t;

    vec_t vecs[14];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ct_op(alu_ct_op), .funct(funct), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .hi(hi), .lo(lo), .illegal(illegal), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ct, input logic [5:0] fn,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid  = 1'b1;
        alu_ct_op = ct;
        funct     = fn;
        src_a     = a;
        src_b     = b;
    endtask

    // Waits for out_valid after an accept edge; returns number of edges taken.
    task automatic waitResult(input string name, output int edges);
        edges = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (in_ready !== 1'b0 && out_valid !== 1'b1) begin
                checkOutput({name, "_busy_in_ready"}, W'(in_ready), W'(0));
            end
            if (out_valid === 1'b1) begin
                edges = k;
                break;
            end
        end
        if (edges == 0) checkOutput({name, "_timeout"}, W'(0), W'(1));
    endtask

    initial begin
        int edges;
        vecs[0]  = '{"addu_wrap", 2'b10, 6'b100001, 32'hFFFFFFFF, 32'h2,        32'h1,        1'b0};
        vecs[1]  = '{"slt_neg",   2'b10, 6'b101010, 32'hFFFFFFFE, 32'h1,        32'h1,        1'b0};
        vecs[2]  = '{"sltu_neg",  2'b10, 6'b101011, 32'hFFFFFFFE, 32'h1,        32'h0,        1'b0};
        vecs[3]  = '{"slt_pos",   2'b10, 6'b101010, 32'h1,        32'hFFFFFFFE, 32'h0,        1'b0};
        vecs[4]  = '{"sltu_pos",  2'b10, 6'b101011, 32'h1,        32'hFFFFFFFE, 32'h1,        1'b0};
        vecs[5]  = '{"add_op00",  2'b00, 6'b000000, 32'h5,        32'h7,        32'hC,        1'b0};
        vecs[6]  = '{"sub_op01",  2'b01, 6'b111111, 32'h3,        32'h5,        32'hFFFFFFFE, 1'b0};
        vecs[7]  = '{"subu",      2'b10, 6'b100011, 32'hA,        32'h3,        32'h7,        1'b0};
        vecs[8]  = '{"and",       2'b10, 6'b100100, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1'b0};
        vecs[9]  = '{"or",        2'b10, 6'b100101, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0};
        vecs[10] = '{"xor",       2'b10, 6'b100110, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
        vecs[11] = '{"nor",       2'b10, 6'b100111, 32'h0F0F0000, 32'h00000F0F, 32'hF0F0F0F0, 1'b0};
        vecs[12] = '{"op11_ill",  2'b11, 6'b100001, 32'h1,        32'h2,        32'h0,        1'b1};
        vecs[13] = '{"funct_ill", 2'b10, 6'b000001, 32'h1,        32'h2,        32'h0,        1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        alu_ct_op = 2'b00; funct = 6'b0; src_a = '0; src_b = '0;
        tick(); tick();
        rst = 1'b0;
        checkOutput("rst_out_valid", W'(out_valid), W'(0));
        checkOutput("rst_in_ready", W'(in_ready), W'(1));
        checkOutput("rst_result", result, 32'h0);
        checkOutput("rst_hi", hi, 32'h0);
        checkOutput("rst_lo", lo, 32'h0);

        // Back-to-back single-cycle table, in_valid held high throughout
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].ct, vecs[i].fn, vecs[i].a, vecs[i].b);
            checkOutput({vecs[i].name, "_in_ready"}, W'(in_ready), W'(1));
            tick();
            checkOutput({vecs[i].name, "_out_valid"}, W'(out_valid), W'(1));
            checkOutput({vecs[i].name, "_result"}, result, vecs[i].res);
            checkOutput({vecs[i].name, "_illegal"}, W'(illegal), W'(vecs[i].ill));
            checkOutput({vecs[i].name, "_div_zero"}, W'(div_zero), W'(0));
        end
        in_valid = 1'b0;
        tick();
        checkOutput("drain_out_valid", W'(out_valid), W'(0));

        // MULTU max*max
        applyStimulus(2'b10, 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        in_valid = 1'b0; src_a = 32'h12345678; src_b = 32'h9;
        checkOutput("mul_in_ready_low", W'(in_ready), W'(0));
        waitResult("mul", edges);
        checkOutput("mul_latency", W'(edges), W'(W + 1));
        checkOutput("mul_hi", hi, 32'hFFFFFFFE);
        checkOutput("mul_lo", lo, 32'h00000001);
        checkOutput("mul_result", result, 32'h00000001);
        applyStimulus(2'b10, 6'b010000, 32'h0, 32'h0);
        tick();
        checkOutput("mfhi_result", result, 32'hFFFFFFFE);
        applyStimulus(2'b10, 6'b010010, 32'h0, 32'h0);
        tick();
        checkOutput("mflo_result", result, 32'h00000001);
        in_valid = 1'b0;
        tick();

        // DIVU 100/7
        applyStimulus(2'b10, 6'b011011, 32'd100, 32'd7);
        tick();
        in_valid = 1'b0; src_b = 32'h0;
        waitResult("div", edges);
        checkOutput("div_latency", W'(edges), W'(W + 1));
        checkOutput("div_lo", lo, 32'd14);
        checkOutput("div_hi", hi, 32'd2);
        checkOutput("div_result", result, 32'd14);
        checkOutput("div_div_zero", W'(div_zero), W'(0));
        tick();

        // DIVU 5/0 completes in one cycle
        applyStimulus(2'b10, 6'b011011, 32'd5, 32'd0);
        tick();
        in_valid = 1'b0;
        checkOutput("divz_out_valid", W'(out_valid), W'(1));
        checkOutput("divz_lo", lo, 32'hFFFFFFFF);
        checkOutput("divz_hi", hi, 32'd5);
        checkOutput("divz_result", result, 32'hFFFFFFFF);
        checkOutput("divz_flag", W'(div_zero), W'(1));
        checkOutput("divz_in_ready", W'(in_ready), W'(1));
        tick();

        // Back-pressure: result held while out_ready low
        out_ready = 1'b0;
        applyStimulus(2'b00, 6'b0, 32'd3, 32'd4);
        tick();
        applyStimulus(2'b00, 6'b0, 32'd10, 32'd20);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", W'(out_valid), W'(1));
            checkOutput("bp_result", result, 32'd7);
            checkOutput("bp_in_ready", W'(in_ready), W'(0));
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", W'(in_ready), W'(1));
        tick();
        checkOutput("bp_next_out_valid", W'(out_valid), W'(1));
        checkOutput("bp_next_result", result, 32'd30);
        in_valid = 1'b0;
        tick();
        checkOutput("bp_drained", W'(out_valid), W'(0));

        // Reset ten cycles into a MULTU
        applyStimulus(2'b10, 6'b011001, 32'd3, 32'd5);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mrst_out_valid", W'(out_valid), W'(0));
        checkOutput("mrst_in_ready", W'(in_ready), W'(1));
        checkOutput("mrst_hi", hi, 32'h0);
        checkOutput("mrst_lo", lo, 32'h0);
        applyStimulus(2'b10, 6'b111111, 32'd1, 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("mrst_ill_out_valid", W'(out_valid), W'(1));
        checkOutput("mrst_ill_flag", W'(illegal), W'(1));
        checkOutput("mrst_ill_result", result, 32'h0);
        repeat (40) tick();
        checkOutput("mrst_discarded", W'(out_valid), W'(0));
        checkOutput("mrst_lo_after", lo, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
